// File: rtl/onn_frame_tx_ctrl_if.sv
// Byte-level valid/ready link between the frame scheduler and the UART byte transmitter.
// The master drives tx_valid/tx_data. The slave drives tx_ready.
interface onn_frame_tx_ctrl_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/onn_frame_tx_ctrl.sv
// Frame transmit scheduler: snapshots the ONN phases and streams header,
// grey-scale pixels and an 8-bit checksum over a valid/ready byte link.
module onn_frame_tx_ctrl #(
  parameter int unsigned N      = 210,
  parameter int unsigned PHI_W  = 4,
  parameter int unsigned GAIN   = 32,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_req,
  input  logic                 settled,
  input  logic [PHI_W*N-1:0]   phi_out,
  onn_frame_tx_ctrl_if.master  tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          frame_count
);
  localparam int unsigned     IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned     PW       = PHI_W + 8;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [2:0] {IDLE, HDR, PIX, CKS, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [7:0]       checksum;
  logic [7:0]       sum_nxt;
  logic             pending;
  logic             xfer;
  logic [PHI_W-1:0] snapshot [N];

  // Product is kept PHI_W+8 bits wide so saturation sees the untruncated value.
  function automatic logic [7:0] grey(input logic [PHI_W-1:0] p);
    logic [PW-1:0] prod;
    prod = PW'(p) * PW'(GAIN);
    return (prod > PW'(255)) ? 8'hFF : prod[7:0];
  endfunction

  always_comb begin
    xfer    = tx.tx_valid & tx.tx_ready;
    idx_nxt = idx + IDX_W'(1);
    sum_nxt = checksum + tx.tx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      checksum    <= '0;
      pending     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      tx.tx_valid <= 1'b0;
      tx.tx_data  <= '0;
      for (int unsigned i = 0; i < N; i++) snapshot[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      // At most one request is remembered while a frame is in progress.
      if (frame_req && state != IDLE) pending <= 1'b1;

      unique case (state)
        IDLE: begin
          if ((frame_req || pending) && settled) begin
            for (int unsigned i = 0; i < N; i++)
              snapshot[i] <= phi_out[PHI_W*i +: PHI_W];
            pending     <= 1'b0;
            idx         <= '0;
            checksum    <= '0;
            busy        <= 1'b1;
            tx.tx_valid <= 1'b1;
            tx.tx_data  <= HEADER;
            state       <= HDR;
          end else if (frame_req) begin
            pending <= 1'b1;
          end
        end
        HDR: begin
          if (xfer) begin
            tx.tx_data <= grey(snapshot[0]);
            state      <= PIX;
          end
        end
        PIX: begin
          if (xfer) begin
            checksum <= sum_nxt;
            if (idx == IDX_LAST) begin
              tx.tx_data <= sum_nxt;
              state      <= CKS;
            end else begin
              idx        <= idx_nxt;
              tx.tx_data <= grey(snapshot[idx_nxt]);
            end
          end
        end
        CKS: begin
          if (xfer) begin
            tx.tx_valid <= 1'b0;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            state       <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
